// File: rtl/call_stack_ctrl_if.sv
// Controller <-> return-address stack bundle.
// Master drives the call/return strobes; slave returns the stack view.
interface call_stack_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int PTR_W  = 3
);
    logic              push;
    logic              pop;
    logic              flush;
    logic              halt;
    logic [ADDR_W-1:0] ret_addr_in;
    logic [ADDR_W-1:0] ret_addr_out;
    logic              ret_valid;
    logic              stack_empty;
    logic              stack_full;
    logic [PTR_W:0]    depth_count;
    logic              overflow;
    logic              underflow;
    logic [1:0]        state;

    modport master (
        output push, pop, flush, halt, ret_addr_in,
        input  ret_addr_out, ret_valid, stack_empty, stack_full,
        input  depth_count, overflow, underflow, state
    );

    modport slave (
        input  push, pop, flush, halt, ret_addr_in,
        output ret_addr_out, ret_valid, stack_empty, stack_full,
        output depth_count, overflow, underflow, state
    );
endinterface

// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack with a registered top-of-stack copy.
// Freezes in HALTED on halt and in FAULT on overflow/underflow.
module call_stack_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    call_stack_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HALTED = 2'b01,
        FAULT  = 2'b10,
        BAD    = 2'b11
    } state_t;

    state_t            state_q, state_n;
    logic [PTR_W:0]    cnt_q, cnt_n;
    logic              ovf_q, ovf_n;
    logic              udf_q, udf_n;
    logic [ADDR_W-1:0] top_q, top_n;
    logic [ADDR_W-1:0] mem [DEPTH];

    logic              we;
    logic [PTR_W-1:0]  widx;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  prv_idx;
    logic              p, q;
    logic              empty, full;

    assign p       = bus.push & ~bus.flush;
    assign q       = bus.pop & ~bus.flush;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign top_idx = cnt_q[PTR_W-1:0] - PTR_W'(1);
    assign prv_idx = cnt_q[PTR_W-1:0] - PTR_W'(2);

    // Next-state, flags, count and storage write decode.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ovf_n   = ovf_q;
        udf_n   = udf_q;
        top_n   = top_q;
        we      = 1'b0;
        widx    = cnt_q[PTR_W-1:0];
        unique case (state_q)
            RUN: begin
                if (bus.halt) begin
                    state_n = HALTED;
                end else if (p && q && !empty) begin
                    we    = 1'b1;
                    widx  = top_idx;
                    top_n = bus.ret_addr_in;
                end else if (p && q) begin
                    udf_n   = 1'b1;
                    state_n = FAULT;
                end else if (p && full) begin
                    ovf_n   = 1'b1;
                    state_n = FAULT;
                end else if (q && empty) begin
                    udf_n   = 1'b1;
                    state_n = FAULT;
                end else if (p) begin
                    we    = 1'b1;
                    cnt_n = cnt_q + (PTR_W+1)'(1);
                    top_n = bus.ret_addr_in;
                end else if (q) begin
                    cnt_n = cnt_q - (PTR_W+1)'(1);
                    top_n = (cnt_q == (PTR_W+1)'(1))
                          ? '0 : mem[prv_idx];
                end
            end
            HALTED, FAULT: begin
            end
            default: state_n = FAULT;
        endcase
    end

    // Control registers; reset clears count, flags and top copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            top_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ovf_q   <= ovf_n;
            udf_q   <= udf_n;
            top_q   <= top_n;
        end
    end

    // Entry storage; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (we && rst) begin
            mem[widx] <= bus.ret_addr_in;
        end
    end

    assign bus.ret_addr_out = top_q;
    assign bus.ret_valid    = !empty && (state_q == RUN);
    assign bus.stack_empty  = empty;
    assign bus.stack_full   = full;
    assign bus.depth_count  = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: directed plan steps then random
// traffic, compared against a queue-based stack model.
module tb_call_stack_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    call_stack_ctrl_if #(.ADDR_W(12), .PTR_W(3)) bus ();

    call_stack_ctrl #(.ADDR_W(12), .DEPTH(8), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] stk[$];
    int          ms;
    bit          movf;
    bit          mudf;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int top;
        top = (stk.size() > 0) ? int'(stk[stk.size()-1]) : 0;
        chk({tag, ".depth"}, int'(bus.depth_count), stk.size());
        chk({tag, ".top"}, int'(bus.ret_addr_out), top);
        chk({tag, ".valid"}, int'(bus.ret_valid),
            int'(stk.size() > 0 && ms == 0));
        chk({tag, ".empty"}, int'(bus.stack_empty), int'(stk.size() == 0));
        chk({tag, ".full"}, int'(bus.stack_full), int'(stk.size() == 8));
        chk({tag, ".ovf"}, int'(bus.overflow), int'(movf));
        chk({tag, ".udf"}, int'(bus.underflow), int'(mudf));
        chk({tag, ".state"}, int'(bus.state), ms);
    endtask

    task automatic model(input bit pu, input bit po, input bit fl,
                         input bit ha, input logic [11:0] a);
        bit pe, qe;
        pe = pu && !fl;
        qe = po && !fl;
        if (ms != 0) return;
        if (ha) ms = 1;
        else if (pe && qe && stk.size() > 0) stk[stk.size()-1] = a;
        else if (pe && qe) begin mudf = 1; ms = 2; end
        else if (pe && stk.size() == 8) begin movf = 1; ms = 2; end
        else if (qe && stk.size() == 0) begin mudf = 1; ms = 2; end
        else if (pe) stk.push_back(a);
        else if (qe) void'(stk.pop_back());
    endtask

    // Drive at posedge+1, let one edge pass, check at posedge+1.
    task automatic cyc(input bit pu, input bit po, input bit fl,
                       input bit ha, input logic [11:0] a,
                       input string tag);
        bus.push        = pu;
        bus.pop         = po;
        bus.flush       = fl;
        bus.halt        = ha;
        bus.ret_addr_in = a;
        @(posedge clk);
        model(pu, po, fl, ha, a);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        stk.delete();
        ms   = 0;
        movf = 0;
        mudf = 0;
        check_all(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ms = 0; movf = 0; mudf = 0;
        bus.push = 0; bus.pop = 0; bus.flush = 0; bus.halt = 0;
        bus.ret_addr_in = '0;
        rst = 1'b0;
        #3;
        check_all("reset");
        rst = 1'b1;

        cyc(1, 0, 0, 0, 12'h010, "p1");
        cyc(1, 0, 0, 0, 12'h020, "p2");
        cyc(1, 0, 0, 0, 12'h030, "p3");
        chk("tp1.top", int'(bus.ret_addr_out), 'h030);
        chk("tp1.depth", int'(bus.depth_count), 3);
        cyc(0, 1, 0, 0, 12'h000, "q1");
        chk("tp2.top1", int'(bus.ret_addr_out), 'h020);
        cyc(0, 1, 0, 0, 12'h000, "q2");
        cyc(0, 1, 0, 0, 12'h000, "q3");
        chk("tp2.empty", int'(bus.stack_empty), 1);

        for (int i = 0; i < 8; i++)
            cyc(1, 0, 0, 0, 12'h100 + 12'(i), "fill");
        cyc(1, 0, 0, 0, 12'h1FF, "ovf");
        chk("tp3.state", int'(bus.state), 2);
        chk("tp3.top", int'(bus.ret_addr_out), 'h107);
        cyc(1, 0, 0, 0, 12'h222, "frz1");
        cyc(0, 1, 0, 0, 12'h000, "frz2");

        do_reset("rst2");
        cyc(0, 1, 0, 0, 12'h000, "udf");
        chk("tp4.udf", int'(bus.underflow), 1);

        do_reset("rst3");
        cyc(1, 0, 0, 0, 12'h010, "pp1");
        cyc(1, 0, 0, 0, 12'h020, "pp2");
        cyc(1, 1, 0, 0, 12'h055, "ovw");
        chk("tp4.ovw", int'(bus.ret_addr_out), 'h055);
        cyc(0, 1, 0, 0, 12'h000, "ovw.pop");
        chk("tp4.under", int'(bus.ret_addr_out), 'h010);

        do_reset("rst4");
        cyc(1, 0, 1, 0, 12'h0EE, "flush");
        cyc(0, 1, 1, 0, 12'h000, "flushq");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 0, 0, 12'h300 + 12'(i), "fill2");
        cyc(1, 0, 0, 1, 12'h3FF, "halt");
        chk("tp5.state", int'(bus.state), 1);
        cyc(0, 1, 0, 0, 12'h000, "halted");

        do_reset("rst5");
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 0, 0, 12'h040 + 12'(i), "five");
        #2;
        do_reset("rst_mid");
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 12'h0AA, "after");
        chk("tp6.top", int'(bus.ret_addr_out), 'h0AA);

        for (int n = 0; n < 400; n++) begin
            int r;
            bit pu, po, fl, ha;
            if (ms != 0 && $urandom_range(0, 3) == 0) do_reset("rnd.rst");
            r  = int'($urandom_range(0, 99));
            pu = (r < 50) || (r >= 90 && r < 94);
            po = (r >= 45 && r < 88) || (r >= 92 && r < 95);
            fl = ($urandom_range(0, 15) == 0);
            ha = ($urandom_range(0, 79) == 0);
            cyc(pu, po, fl, ha, 12'($urandom_range(0, 4095)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Hardware return-address stack for the 19-bit pipelined core.
- Driven by the controller's push (call: JumpSel+push) and pop (return: StackSel+pop) strobes; supplies the return PC to the fetch mux.
- Tracks depth, detects overflow/underflow, and freezes on Halt or fault.
- Sits between decode/controller and the PC-select logic.

Parameters:
ADDR_W, 12, width of a program address / stack entry
DEPTH, 8, number of stack entries (power of two)
PTR_W, 3, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
push  input  1  call strobe from controller; store ret_addr_in
pop  input  1  return strobe from controller; remove top entry
flush  input  1  current-cycle push/pop belong to a squashed instruction; ignore them
halt  input  1  Halt decoded; freeze stack
ret_addr_in  input  ADDR_W  return address (PC+1 of the call)
ret_addr_out  output  ADDR_W  current top-of-stack entry
ret_valid  output  1  ret_addr_out usable (non-empty and state RUN)
stack_empty  output  1  count == 0
stack_full  output  1  count == DEPTH
depth_count  output  PTR_W+1  entries held, 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
state  output  2  00 RUN, 01 HALTED, 10 FAULT

Behaviour:
- Reset (rst=0, async):
  - count=0, state=RUN, overflow=0, underflow=0, ret_addr_out=0.
  - Storage contents are don't-care.
- Effective strobes: p = push & ~flush, q = pop & ~flush. Both are evaluated only in RUN.
- ret_addr_out is a registered copy of the top entry, updated on the same edge as any stack change.
  - After a push it equals the pushed value.
  - After a pop it equals the new top, or 0 if the stack becomes empty.
- A return consumes ret_addr_out in the cycle pop is asserted (zero latency). The stack change is visible the next cycle.
- RUN transitions, first match wins:
  1. halt=1 -> HALTED. p/q ignored, flags unchanged.
  2. p & q & count>0 -> overwrite top with ret_addr_in. Count unchanged (return followed by call).
  3. p & q & count==0 -> underflow=1, FAULT, no write.
  4. p & count==DEPTH -> overflow=1, FAULT, no write, count unchanged.
  5. q & count==0 -> underflow=1, FAULT.
  6. p -> write entry[count], count+1.
  7. q -> count-1.
  8. Otherwise hold.
- HALTED: all inputs except rst ignored; held until reset.
- FAULT: all inputs except rst ignored; flags sticky; held until reset.
- Derived outputs:
  - ret_valid = (count!=0) & (state==RUN).
  - stack_empty and stack_full are decoded from registered count (no glitch paths from inputs).
- Pointer arithmetic:
  - Write index = count[PTR_W-1:0].
  - Top index = count-1.
  - Count never wraps; it saturates at 0 and DEPTH through the fault rules.
- Reset asserted mid-operation aborts any in-progress write; the post-reset state is as specified above.
- state 11 is unused; if reached, the next edge returns to FAULT.

Test Plan:
- Reset, then push 0x010,0x020,0x030 on consecutive cycles -> depth_count=3, ret_addr_out=0x030, ret_valid=1, no flags.
- From the above, pop x3 -> ret_addr_out sequence 0x030,0x020,0x010, then 0 with stack_empty=1, ret_valid=0.
- Push 8 values 0x100..0x107, then a 9th push 0x1FF -> stack_full=1, overflow=1, state=10, ret_addr_out remains 0x107. Further pushes/pops cause no change until rst.
- Pop on empty after reset -> underflow=1, state=10. Separately, push+pop same cycle with count=2 (top 0x020, ret_addr_in=0x055) -> count stays 2, ret_addr_out=0x055.
- push=1 with flush=1 -> no change (count 0, ret_valid 0). halt=1 together with push while full -> state=01, overflow stays 0.
- Drop rst low mid-sequence with count=5 -> asynchronously count=0, state=00, flags clear. Next push 0x0AA -> ret_addr_out=0x0AA.
